// File: rtl/lms_pkg.sv
// Shared package for the LMS adaptive filter blocks.
// Holds the Q1.15 format constants and the state encoding of the
// per-tap weight-update FSM.
package lms_pkg;

  localparam int LMS_DW   = 16;  // sample / weight width, signed Q1.15
  localparam int LMS_FRAC = 15;  // fractional bits of a Q1.15 value

  localparam logic signed [LMS_DW-1:0] LMS_WMAX = 16'sh7FFF;
  localparam logic signed [LMS_DW-1:0] LMS_WMIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MULT,
    UPD,
    WRITE
  } lms_upd_state_t;

endpackage

// File: rtl/lms_weight_update_if.sv
// Bus bundle of the LMS weight-update stage.
// Carries the request handshake (valid_in/ready, x_in, err_in, adapt_en,
// done, sat_flag) and the coefficient-register port (w_rd_en, w_rd_data,
// w_wr_en, w_wr_data).
//   slave  : the update stage itself
//   master : the requester plus the coefficient register
interface lms_weight_update_if;
  import lms_pkg::*;

  logic                     valid_in;
  logic signed [LMS_DW-1:0] x_in;
  logic signed [LMS_DW-1:0] err_in;
  logic                     adapt_en;
  logic                     ready;
  logic                     w_rd_en;
  logic signed [LMS_DW-1:0] w_rd_data;
  logic                     w_wr_en;
  logic signed [LMS_DW-1:0] w_wr_data;
  logic                     done;
  logic                     sat_flag;

  modport slave (
    input  valid_in, x_in, err_in, adapt_en, w_rd_data,
    output ready, w_rd_en, w_wr_en, w_wr_data, done, sat_flag
  );

  modport master (
    output valid_in, x_in, err_in, adapt_en, w_rd_data,
    input  ready, w_rd_en, w_wr_en, w_wr_data, done, sat_flag
  );

endinterface

// File: rtl/lms_sat_add.sv
// Combinational saturating adder: 16-bit signed a plus 17-bit signed b,
// clamped to the 16-bit signed range.
//   a   : 16-bit signed operand (Q1.15)
//   b   : 17-bit signed operand
//   sum : saturated 16-bit result
//   ovf : 1 when the exact sum was outside the 16-bit range
module lms_sat_add
  import lms_pkg::*;
(
  input  logic signed [LMS_DW-1:0] a,
  input  logic signed [LMS_DW:0]   b,
  output logic signed [LMS_DW-1:0] sum,
  output logic                     ovf
);

  // Two guard bits so the exact sum can never wrap, whatever b holds.
  localparam logic signed [LMS_DW+1:0] S_MAX = {{2{LMS_WMAX[LMS_DW-1]}}, LMS_WMAX};
  localparam logic signed [LMS_DW+1:0] S_MIN = {{2{LMS_WMIN[LMS_DW-1]}}, LMS_WMIN};

  logic signed [LMS_DW+1:0] s_wide;

  assign s_wide = {{2{a[LMS_DW-1]}}, a} + {b[LMS_DW], b};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    sum = s_wide[LMS_DW-1:0];
    ovf = 1'b0;
    if (s_wide > S_MAX) begin
      sum = LMS_WMAX;
      ovf = 1'b1;
    end else if (s_wide < S_MIN) begin
      sum = LMS_WMIN;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient update for one tap:
//   w_new = sat16(w + ((e*x) >>> (15+MU_SHIFT)))
// Sequence per accepted request: IDLE -> READ -> MULT -> UPD -> WRITE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : lms_weight_update_if.slave (handshake + coefficient register)
// Parameters:
//   DW       : data width, only 16 supported
//   MU_SHIFT : step size mu = 2^-MU_SHIFT, legal range 0..15
module lms_weight_update
  import lms_pkg::*;
#(
  parameter int DW       = LMS_DW,
  parameter int MU_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  lms_weight_update_if.slave  bus
);

  localparam int SHIFT = LMS_FRAC + MU_SHIFT;

  lms_upd_state_t state_q, state_d;

  logic signed [DW-1:0]   x_q, e_q, w_q;
  logic                   adapt_q;
  logic signed [2*DW-1:0] p_q;

  logic signed [DW:0]     step;
  logic signed [DW-1:0]   sum_c;
  logic                   ovf_c;

  logic                   ready_q, ready_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
  logic signed [DW-1:0]   wr_data_q, wr_data_d;
  logic                   done_q, done_d;
  logic                   sat_q, sat_d;

  // Largest magnitude is (-1)*(-1) = 2^30; shifted by at least 15 it is
  // 2^15, which still fits the 17-bit step.
  assign step = (DW+1)'(p_q >>> SHIFT);

  lms_sat_add u_sat_add (
    .a   (w_q),
    .b   (step),
    .sum (sum_c),
    .ovf (ovf_c)
  );

  // Next state and the values the registered outputs take in that state.
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    done_d    = 1'b0;
    sat_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      READ:  state_d = MULT;
      MULT:  state_d = UPD;
      UPD: begin
        state_d = WRITE;
        done_d  = 1'b1;
        sat_d   = ovf_c;
        if (adapt_q) begin
          wr_en_d   = 1'b1;
          wr_data_d = sum_c;
        end
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  // NOTE: the datapath registers are reset too, so an aborted request can
  // never leak an old operand into the next update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      e_q     <= '0;
      adapt_q <= 1'b0;
      w_q     <= '0;
      p_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            x_q     <= bus.x_in;
            e_q     <= bus.err_in;
            adapt_q <= bus.adapt_en;
          end
        end
        READ:    w_q <= bus.w_rd_data;
        MULT:    p_q <= (2*DW)'(x_q) * (2*DW)'(e_q);
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.w_rd_en   = rd_en_q;
  assign bus.w_wr_en   = wr_en_q;
  assign bus.w_wr_data = wr_data_q;
  assign bus.done      = done_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update.
// dut0 runs with MU_SHIFT=2, dut1 with MU_SHIFT=0; the bench plays the
// requester and the per-tap coefficient register for both.
module tb_lms_weight_update;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       valid_v, adapt_v;
  logic [1:0][15:0] x_v, e_v, w_v;

  int checks = 0;
  int errors = 0;

  lms_weight_update_if if0 ();
  lms_weight_update_if if1 ();

  assign if0.valid_in  = valid_v[0];
  assign if0.x_in      = x_v[0];
  assign if0.err_in    = e_v[0];
  assign if0.adapt_en  = adapt_v[0];
  assign if0.w_rd_data = w_v[0];
  assign if1.valid_in  = valid_v[1];
  assign if1.x_in      = x_v[1];
  assign if1.err_in    = e_v[1];
  assign if1.adapt_en  = adapt_v[1];
  assign if1.w_rd_data = w_v[1];

  wire [1:0]       ready_w = {if1.ready,    if0.ready};
  wire [1:0]       rd_w    = {if1.w_rd_en,  if0.w_rd_en};
  wire [1:0]       wr_w    = {if1.w_wr_en,  if0.w_wr_en};
  wire [1:0]       done_w  = {if1.done,     if0.done};
  wire [1:0]       sat_w   = {if1.sat_flag, if0.sat_flag};
  wire [1:0][15:0] wrd_w   = {if1.w_wr_data, if0.w_wr_data};

  lms_weight_update #(.DW(16), .MU_SHIFT(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  lms_weight_update #(.DW(16), .MU_SHIFT(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; waits a bounded number of cycles for ready.
  task automatic wait_ready(input int d, input string tag);
    int n = 0;
    while (ready_w[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready_wait"}, 32'(ready_w[d]), 32'd1);
  endtask

  // One full request with cycle-accurate checks from accept (edge N) to N+5.
  task automatic request(input int d, input logic [15:0] w, input logic [15:0] x,
                         input logic [15:0] e, input logic adapt,
                         input logic [15:0] exp_res, input logic exp_sat,
                         input string tag);
    wait_ready(d, tag);
    w_v[d]     = w;
    x_v[d]     = x;
    e_v[d]     = e;
    adapt_v[d] = adapt;
    valid_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[d] = 1'b0;
    check({tag, ":rd_n1"},    32'(rd_w[d]),    32'd1);
    check({tag, ":ready_n1"}, 32'(ready_w[d]), 32'd0);
    check({tag, ":wr_n1"},    32'(wr_w[d]),    32'd0);
    repeat (2) begin
      @(negedge clk);
      check({tag, ":quiet_mid"}, 32'({rd_w[d], wr_w[d], done_w[d], ready_w[d]}), 32'd0);
    end
    @(negedge clk);
    check({tag, ":done_n4"},  32'(done_w[d]), 32'd1);
    check({tag, ":wr_n4"},    32'(wr_w[d]),   32'(adapt));
    check({tag, ":data_n4"},  32'(wrd_w[d]),  adapt ? 32'(exp_res) : 32'd0);
    check({tag, ":sat_n4"},   32'(sat_w[d]),  32'(exp_sat));
    check({tag, ":rd_n4"},    32'(rd_w[d]),   32'd0);
    if (adapt) w_v[d] = exp_res;
    @(negedge clk);
    check({tag, ":ready_n5"}, 32'(ready_w[d]), 32'd1);
    check({tag, ":idle_n5"},  32'({done_w[d], wr_w[d], sat_w[d], wrd_w[d]}), 32'd0);
  endtask

  initial begin
    int nd, nr, first_rd, second_rd;
    reset   = 1'b1;
    valid_v = '0;
    adapt_v = '0;
    x_v     = '0;
    e_v     = '0;
    w_v     = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d:ready", d), 32'(ready_w[d]), 32'd1);
      check($sformatf("reset%0d:outs", d),
            32'({rd_w[d], wr_w[d], done_w[d], sat_w[d], wrd_w[d]}), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // MU_SHIFT=2: 0.5*0.5 = 2^28 >>> 17 = 0x0800
    request(0, 16'h0000, 16'h4000, 16'h4000, 1'b1, 16'h0800, 1'b0, "basic");
    // -1 LSB * 1 LSB = -1, floor shift keeps -1
    request(0, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, "trunc");
    // -0.5*0.5 = -2^28 >>> 17 = -0x800; 0x1000 - 0x0800
    request(0, 16'h1000, 16'hC000, 16'h4000, 1'b1, 16'h0800, 1'b0, "neg_step");
    // (-1)*(-1) = 2^30 >>> 17 = 0x2000
    request(0, 16'h0000, 16'h8000, 16'h8000, 1'b1, 16'h2000, 1'b0, "m1m1_mu2");
    // adapt_en=0: done without a write
    request(0, 16'h0100, 16'h4000, 16'h4000, 1'b0, 16'h0900, 1'b0, "no_adapt");

    // MU_SHIFT=0: 0x3FFF0001 >>> 15 = 0x7FFE; 0x7F00 + 0x7FFE saturates high
    request(1, 16'h7F00, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, "pos_sat");
    // step = -32767; 0x8100 + step saturates low
    request(1, 16'h8100, 16'h7FFF, 16'h8000, 1'b1, 16'h8000, 1'b1, "neg_sat");
    // step = +32768 alone saturates
    request(1, 16'h0000, 16'h8000, 16'h8000, 1'b1, 16'h7FFF, 1'b1, "m1m1_sat");
    // step = +32768 on w=-32768 lands exactly on 0
    request(1, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0, "m1m1_zero");
    // saturation reported even with the write suppressed
    request(1, 16'h7F00, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, "sat_noadapt");

    // valid_in pulsed during MULT is ignored
    wait_ready(0, "pulse");
    w_v[0] = 16'h0000; x_v[0] = 16'h4000; e_v[0] = 16'h4000; adapt_v[0] = 1'b1;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    @(negedge clk);
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    nd = 0; nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_w[0]) nd++;
      if (rd_w[0]) nr++;
      @(negedge clk);
    end
    check("pulse:done_count", 32'(nd), 32'd1);
    check("pulse:rd_count",   32'(nr), 32'd0);

    // valid_in held high: accepted every 5 cycles
    wait_ready(0, "held");
    w_v[0] = 16'h0000; x_v[0] = 16'h4000; e_v[0] = 16'h4000; adapt_v[0] = 1'b1;
    valid_v[0] = 1'b1;
    @(posedge clk);
    nd = 0; nr = 0; first_rd = -1; second_rd = -1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (rd_w[0]) begin
        nr++;
        if (first_rd < 0) first_rd = i;
        else if (second_rd < 0) second_rd = i;
      end
      if (done_w[0]) nd++;
      if (rd_w[0] && wr_w[0]) check("held:rd_wr_overlap", 32'd1, 32'd0);
      if (wr_w[0]) check("held:data", 32'(wrd_w[0]), 32'h0800);
    end
    valid_v[0] = 1'b0;
    check("held:rd_count",   32'(nr), 32'd3);
    check("held:done_count", 32'(nd), 32'd3);
    check("held:first_rd",   32'(first_rd), 32'd1);
    check("held:period",     32'(second_rd - first_rd), 32'd5);
    wait_ready(0, "held_end");

    // reset asserted mid-MULT aborts the request
    wait_ready(0, "rst");
    w_v[0] = 16'h0000; x_v[0] = 16'h4000; e_v[0] = 16'h4000; adapt_v[0] = 1'b1;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst:ready", 32'(ready_w[0]), 32'd1);
    check("rst:outs",  32'({rd_w[0], wr_w[0], done_w[0], sat_w[0], wrd_w[0]}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_w[0]) nr++;
      if (done_w[0]) nd++;
    end
    check("rst:no_write", 32'(nr), 32'd0);
    check("rst:no_done",  32'(nd), 32'd0);
    check("rst:ready_after", 32'(ready_w[0]), 32'd1);

    // the stage still works after the abort
    request(0, 16'h0000, 16'h4000, 16'h4000, 1'b1, 16'h0800, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
